// File: rtl/rom_dump_sequencer.sv
// Automatic ROM dump sequencer: rewinds the reader to address 0, then streams every {address, data} word.
// Optional ROM_DUMP_CHECKSUM_EN builds a 16-bit running sum of streamed words.
module rom_dump_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int PULSE_CYCLES  = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] reader_address,
  input  logic [DATA_WIDTH-1:0]    reader_data,
  output logic                     inc_strobe,
  output logic                     dec_strobe,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              checksum
);
  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] LAST  = {1'b0, {ADDRESS_WIDTH{1'b1}}};
  localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, REW_PULSE, REW_GAP, SETTLE, CAPTURE, SEND, STEP_PULSE, STEP_GAP, DONE_ST
  } state_t;

  state_t                 state;
  logic [15:0]            cnt;
  logic [ADDRESS_WIDTH:0] idx;
  logic [ADDRESS_WIDTH:0] rew_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      rew_cnt    <= '0;
      inc_strobe <= 1'b0;
      dec_strobe <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (abort) begin
      // Pending word is dropped; error is left as it was.
      state      <= IDLE;
      inc_strobe <= 1'b0;
      dec_strobe <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          error   <= 1'b0;
          idx     <= '0;
          rew_cnt <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          if (reader_address == '0) state <= SETTLE;
          else begin
            state      <= REW_PULSE;
            dec_strobe <= 1'b1;
          end
        end
        REW_PULSE: if (cnt == PULSE_LAST) begin
          cnt        <= '0;
          dec_strobe <= 1'b0;
          rew_cnt    <= rew_cnt + 1'b1;
          state      <= REW_GAP;
        end else cnt <= cnt + 1'b1;
        REW_GAP: if (cnt == GAP_LAST) begin
          cnt <= '0;
          if (reader_address == '0) state <= SETTLE;
          else if (rew_cnt < DEPTH) begin
            state      <= REW_PULSE;
            dec_strobe <= 1'b1;
          end else begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end else cnt <= cnt + 1'b1;
        SETTLE: if (cnt == SETTLE_LAST) begin
          cnt   <= '0;
          state <= CAPTURE;
        end else cnt <= cnt + 1'b1;
        CAPTURE: begin
          out_data  <= reader_data;
          out_addr  <= reader_address;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= DONE_ST;
          end else begin
            idx        <= idx + 1'b1;
            inc_strobe <= 1'b1;
            state      <= STEP_PULSE;
          end
        end
        STEP_PULSE: if (cnt == PULSE_LAST) begin
          cnt        <= '0;
          inc_strobe <= 1'b0;
          state      <= STEP_GAP;
        end else cnt <= cnt + 1'b1;
        STEP_GAP: if (cnt == GAP_LAST) begin
          cnt   <= '0;
          state <= SETTLE;
        end else cnt <= cnt + 1'b1;
        DONE_ST: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_DUMP_CHECKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk) begin
    if (!reset_n) csum <= '0;
    else if (!abort && state == IDLE && start) csum <= '0;
    else if (out_valid && out_ready) csum <= csum + 16'(out_data);
  end
  assign checksum = csum;
`else
  assign checksum = '0;
`endif
endmodule
